// File: rtl/reu_xfer_sequencer.sv
// REU DMA transfer sequencer.
// Owns the C64 DMA handshake and steps stash/fetch/swap/verify transfers one
// byte per PHI2 cycle. Bus, RAM and latch strobes are decoded combinationally
// from the registered state so that they are stable for the whole PHI2 period
// and are acted on at its closing negedge.
module reu_xfer_sequencer #(
    parameter int unsigned START_DELAY  = 1,    // nDMA-low cycles before the first transfer cycle (1..3)
    parameter bit          VERIFY_ABORT = 1'b1  // a verify mismatch ends the transfer
) (
    input  logic       PHI2,
    input  logic       Reset,
    input  logic       Execute,
    input  logic [1:0] XferType,
    input  logic       Length1,
    input  logic       BA,
    input  logic       VerifyMatch,
    output logic       nDMA,
    output logic       Busy,
    output logic       C64RnW,
    output logic       C64AddrOE,
    output logic       C64DataOE,
    output logic       RAMRD,
    output logic       RAMWR,
    output logic       LatchC64,
    output logic       LatchRAM,
    output logic       IncCA,
    output logic       IncREUA,
    output logic       DecLen,
    output logic       XferEnd,
    output logic       SetEndOfBlock,
    output logic       SetVerifyErr
);

    localparam logic [1:0] TYPE_STASH  = 2'b00;
    localparam logic [1:0] TYPE_FETCH  = 2'b01;
    localparam logic [1:0] TYPE_SWAP   = 2'b10;
    localparam logic [1:0] TYPE_VERIFY = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2,
        SWAPW = 2'd3
    } state_t;

    state_t     stateReg, stateNext;
    logic [1:0] xTypeReg, xTypeNext;
    logic [1:0] delayReg, delayNext;

    logic advance;
    logic lastByte;
    logic verifyAbort;

    // State, captured transfer type and start-delay counter, all on the falling PHI2 edge.
    always_ff @(negedge PHI2) begin
        if (Reset) begin
            stateReg <= IDLE;
            xTypeReg <= TYPE_STASH;
            delayReg <= 2'd0;
        end else begin
            stateReg <= stateNext;
            xTypeReg <= xTypeNext;
            delayReg <= delayNext;
        end
    end

    // The DMA request and busy flag come from registered state only, so they stay glitch-free.
    assign nDMA = (stateReg == IDLE);
    assign Busy = (stateReg != IDLE);

    // Next-state and per-cycle strobe decode; Reset suppresses every strobe in its own cycle.
    always_comb begin
        stateNext     = stateReg;
        xTypeNext     = xTypeReg;
        delayNext     = delayReg;
        C64RnW        = 1'b1;
        C64AddrOE     = 1'b0;
        C64DataOE     = 1'b0;
        RAMRD         = 1'b0;
        RAMWR         = 1'b0;
        LatchC64      = 1'b0;
        LatchRAM      = 1'b0;
        advance       = 1'b0;
        lastByte      = 1'b0;
        verifyAbort   = 1'b0;
        SetVerifyErr  = 1'b0;

        if (!Reset) begin
            unique case (stateReg)
                IDLE: begin
                    if (Execute) begin
                        stateNext = START;
                        xTypeNext = XferType;
                        delayNext = 2'(START_DELAY);
                    end
                end
                START: begin
                    // The cycle that takes the counter to zero is the last nDMA-low wait cycle.
                    delayNext = delayReg - 2'd1;
                    if (delayReg <= 2'd1) begin
                        stateNext = XFER;
                    end
                end
                XFER: begin
                    if (BA) begin
                        unique case (xTypeReg)
                            TYPE_STASH: begin
                                // RAM writes straight off the C64 data bus.
                                C64AddrOE = 1'b1;
                                LatchC64  = 1'b1;
                                RAMWR     = 1'b1;
                                advance   = 1'b1;
                            end
                            TYPE_FETCH: begin
                                C64RnW    = 1'b0;
                                C64AddrOE = 1'b1;
                                C64DataOE = 1'b1;
                                RAMRD     = 1'b1;
                                LatchRAM  = 1'b1;
                                advance   = 1'b1;
                            end
                            TYPE_SWAP: begin
                                // Read both sides into the latches; the write-back happens in SWAPW.
                                C64AddrOE = 1'b1;
                                RAMRD     = 1'b1;
                                LatchC64  = 1'b1;
                                LatchRAM  = 1'b1;
                                stateNext = SWAPW;
                            end
                            TYPE_VERIFY: begin
                                C64AddrOE = 1'b1;
                                RAMRD     = 1'b1;
                                advance   = 1'b1;
                                if (!VerifyMatch) begin
                                    SetVerifyErr = 1'b1;
                                    verifyAbort  = VERIFY_ABORT;
                                end
                            end
                        endcase
                    end
                end
                SWAPW: begin
                    if (BA) begin
                        // Latch B goes to the C64 (address still driven), latch A goes to RAM.
                        C64RnW    = 1'b0;
                        C64AddrOE = 1'b1;
                        C64DataOE = 1'b1;
                        RAMWR     = 1'b1;
                        advance   = 1'b1;
                        stateNext = XFER;
                    end
                end
            endcase

            lastByte = advance & Length1;
            if (lastByte || verifyAbort) begin
                stateNext = IDLE;
            end
        end

        IncCA         = advance;
        IncREUA       = advance;
        DecLen        = advance;
        SetEndOfBlock = lastByte;
        XferEnd       = lastByte | verifyAbort;
    end

endmodule

// File: tb/tb_reu_xfer_sequencer.sv
// Bench for reu_xfer_sequencer: two instances (verify-abort on / off) share
// one stimulus stream. Each transfer is expanded up front into the list of
// bus cycles it must produce; stalls hold the list, everything else pops it.
module tb_reu_xfer_sequencer;

    localparam int SD = 1;

    // Output vector bit masks: {nDMA,Busy,RnW,AddrOE,DataOE,RD,WR,LC,LR,IncCA,IncREUA,DecLen,End,EOB,VErr}
    localparam logic [14:0] M_NDMA = 15'h4000;
    localparam logic [14:0] M_BUSY = 15'h2000;
    localparam logic [14:0] M_RNW  = 15'h1000;
    localparam logic [14:0] M_AOE  = 15'h0800;
    localparam logic [14:0] M_DOE  = 15'h0400;
    localparam logic [14:0] M_RD   = 15'h0200;
    localparam logic [14:0] M_WR   = 15'h0100;
    localparam logic [14:0] M_LC   = 15'h0080;
    localparam logic [14:0] M_LR   = 15'h0040;
    localparam logic [14:0] M_ADV  = 15'h0038;
    localparam logic [14:0] M_END  = 15'h0004;
    localparam logic [14:0] M_EOB  = 15'h0002;
    localparam logic [14:0] M_VERR = 15'h0001;
    localparam logic [14:0] V_IDLE = M_NDMA | M_RNW;
    localparam logic [14:0] V_HOLD = M_BUSY | M_RNW;

    typedef struct packed {
        logic        stallable;
        logic [14:0] vec;
    } step_t;
    typedef step_t stepq_t[$];

    logic       PHI2 = 1'b1;
    logic       Reset = 1'b1;
    logic       Execute = 1'b0;
    logic [1:0] XferType = 2'b00;
    logic       Length1 = 1'b0;
    logic       BA = 1'b1;
    logic       VerifyMatch = 1'b1;
    wire [14:0] obs [2];

    always #5 PHI2 = ~PHI2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            reu_xfer_sequencer #(
                .START_DELAY (SD),
                .VERIFY_ABORT(gi == 0)
            ) dut (
                .PHI2         (PHI2),
                .Reset        (Reset),
                .Execute      (Execute),
                .XferType     (XferType),
                .Length1      (Length1),
                .BA           (BA),
                .VerifyMatch  (VerifyMatch),
                .nDMA         (obs[gi][14]),
                .Busy         (obs[gi][13]),
                .C64RnW       (obs[gi][12]),
                .C64AddrOE    (obs[gi][11]),
                .C64DataOE    (obs[gi][10]),
                .RAMRD        (obs[gi][9]),
                .RAMWR        (obs[gi][8]),
                .LatchC64     (obs[gi][7]),
                .LatchRAM     (obs[gi][6]),
                .IncCA        (obs[gi][5]),
                .IncREUA      (obs[gi][4]),
                .DecLen       (obs[gi][3]),
                .XferEnd      (obs[gi][2]),
                .SetEndOfBlock(obs[gi][1]),
                .SetVerifyErr (obs[gi][0])
            );
        end
    endgenerate

    int          checkCount = 0;
    int          passCount  = 0;
    stepq_t      qA, qB;          // A: abort on mismatch, B: run to length
    int          bytesDone = 0;   // bytes completed, as a register block would count them
    int          curLen = 1;
    logic [15:0] curMM = '0;      // bit b set: byte b mismatches in a verify
    int          xferNum = 0;

    // Every bus cycle a transfer of this type, length and mismatch pattern must produce.
    function automatic stepq_t buildSteps(input logic [1:0] t, input int len,
                                          input logic [15:0] mm, input bit abort);
        stepq_t      q;
        step_t       s;
        logic [14:0] v;
        bit          stop;
        for (int i = 0; i < SD; i++) begin
            s.stallable = 1'b0;
            s.vec       = V_HOLD;
            q.push_back(s);
        end
        for (int b = 0; b < len; b++) begin
            v    = M_BUSY;
            stop = 1'b0;
            case (t)
                2'd0: v = v | M_RNW | M_AOE | M_LC | M_WR | M_ADV;
                2'd1: v = v | M_AOE | M_DOE | M_RD | M_LR | M_ADV;
                2'd2: begin
                    s.stallable = 1'b1;
                    s.vec       = M_BUSY | M_RNW | M_AOE | M_RD | M_LC | M_LR;
                    q.push_back(s);
                    v = v | M_AOE | M_DOE | M_WR | M_ADV;
                end
                default: begin
                    v = v | M_RNW | M_AOE | M_RD | M_ADV;
                    if (mm[b % 16]) begin
                        v = v | M_VERR;
                        if (abort) begin
                            v    = v | M_END;
                            stop = 1'b1;
                        end
                    end
                end
            endcase
            if (b == len - 1) v = v | M_END | M_EOB;
            s.stallable = 1'b1;
            s.vec       = v;
            q.push_back(s);
            if (stop) break;
        end
        return q;
    endfunction

    function automatic logic [14:0] expOf(input stepq_t q, input bit ba, input bit rst);
        if (q.size() == 0) return V_IDLE;
        if (rst) return V_HOLD;
        if (q[0].stallable && !ba) return V_HOLD;
        return q[0].vec;
    endfunction

    task automatic check(input string tag, input logic [14:0] o, input logic [14:0] e);
        checkCount++;
        assert (o === e) passCount++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    // One PHI2 period: drive after the falling edge, check mid-period, then advance the model.
    task automatic cycle(input bit ex, input logic [1:0] xt, input bit ba, input bit vm,
                         input bit rst, input string tag);
        logic [14:0] eA, eB;
        bit          emptyA, emptyB;
        @(negedge PHI2);
        #1;
        Reset       = rst;
        Execute     = ex;
        XferType    = xt;
        BA          = ba;
        VerifyMatch = vm;
        Length1     = (curLen - bytesDone == 1);
        emptyA      = (qA.size() == 0);
        emptyB      = (qB.size() == 0);
        eA          = expOf(qA, ba, rst);
        eB          = expOf(qB, ba, rst);
        @(posedge PHI2);
        check({tag, " abort"}, obs[0], eA);
        check({tag, " run"}, obs[1], eB);
        if (rst) begin
            qA.delete();
            qB.delete();
        end else begin
            if (!emptyA && (!qA[0].stallable || ba)) void'(qA.pop_front());
            if (!emptyB && (!qB[0].stallable || ba)) begin
                if ((qB[0].vec & M_ADV) != 0) bytesDone++;
                void'(qB.pop_front());
            end
            if (ex && emptyA) qA = buildSteps(xt, curLen, curMM, 1'b1);
            if (ex && emptyB) begin
                qB        = buildSteps(xt, curLen, curMM, 1'b0);
                bytesDone = 0;
            end
        end
    endtask

    task automatic runTransfer(input logic [1:0] t, input int len, input logic [15:0] mm,
                               input int stallPct, input int stallAt, input int stallCycles,
                               input int noisePct, input int resetAt);
        int         n;
        int         stallCnt;
        bit         ba, ex, vm, rst;
        logic [1:0] xt;
        xferNum++;
        $display("xfer %0d: type=%0d len=%0d mismatch=%h stall%%=%0d reset_at=%0d",
                 xferNum, t, len, mm, stallPct, resetAt);
        curLen   = len;
        curMM    = mm;
        stallCnt = 0;
        cycle(1'b1, t, 1'b1, 1'b1, 1'b0, $sformatf("x%0d start", xferNum));
        n = 1;
        while ((qA.size() > 0 || qB.size() > 0) && n < 300) begin
            ba = ($urandom_range(99) >= stallPct);
            if (bytesDone == stallAt && stallCnt < stallCycles) begin
                ba = 1'b0;
                stallCnt++;
            end
            ex = (qA.size() > 0 && qB.size() > 0 && $urandom_range(99) < noisePct);
            xt = 2'($urandom_range(3));
            vm = (t == 2'd3) ? !mm[bytesDone % 16] : 1'($urandom_range(1));
            rst = (n == resetAt);
            cycle(ex, xt, ba, vm, rst, $sformatf("x%0d c%0d", xferNum, n));
            n++;
        end
        if (n >= 300) begin
            checkCount++;
            $error("FAIL x%0d timeout observed=busy expected=idle within 300 cycles", xferNum);
            qA.delete();
            qB.delete();
        end
        cycle(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, $sformatf("x%0d after", xferNum));
    endtask

    initial begin
        // Reset state, then one idle cycle with Reset released.
        cycle(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, "reset");
        cycle(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, "reset2");
        cycle(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, "idle");

        runTransfer(2'd0, 3, 16'h0000, 0, -1, 0, 0, -1);   // stash, 3 bytes
        runTransfer(2'd1, 2, 16'h0000, 0, 1, 4, 0, -1);    // fetch, 4-cycle stall after byte 1
        runTransfer(2'd2, 1, 16'h0000, 0, -1, 0, 0, -1);   // swap, single byte
        runTransfer(2'd3, 4, 16'h0002, 0, -1, 0, 0, -1);   // verify, mismatch on byte 2
        runTransfer(2'd3, 3, 16'h0004, 0, -1, 0, 0, -1);   // verify, mismatch on the last byte
        runTransfer(2'd2, 3, 16'h0000, 0, -1, 0, 0, 3);    // swap, reset while in the write cycle
        runTransfer(2'd0, 3, 16'h0000, 0, -1, 0, 100, -1); // stash with Execute held during busy
        runTransfer(2'd2, 2, 16'h0000, 30, -1, 0, 100, -1);

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  t;
            logic [15:0] mm;
            t  = 2'($urandom_range(3));
            mm = ($urandom_range(2) == 0) ? 16'(1 << $urandom_range(5)) : 16'h0000;
            runTransfer(t, $urandom_range(1, 6), mm, 25, -1, 0, 15,
                        ($urandom_range(7) == 0) ? $urandom_range(1, 6) : -1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
